count_bcd_display: RTL and testbench

- Downstream consumer of the 6-bit synchronous counter outputs (the 35→10 down-counter family): converts the binary count into two BCD digits and drives two 7-segment digit patterns.
- Conversion is serial double-dabble (shift/add-3), one bit per clock, under a start/busy/done handshake.
- Optional auto mode re-converts whenever the counter value changes, so the display tracks the counter without external sequencing.

---
 rtl/count_bcd_display.sv | 123 ++++++++++++
 tb/tb_count_bcd_display.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/count_bcd_display.sv
// Serial double-dabble converter that turns a binary counter value into two
// BCD digits and registered 7-segment patterns under a start/busy/done handshake.
module count_bcd_display #(
    parameter int WIDTH    = 6,
    parameter bit AUTO     = 1'b1,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic             clk,
    input  logic             CLR,
    input  logic [WIDTH-1:0] Q_in,
    input  logic             load,
    output logic             busy,
    output logic             done,
    output logic [3:0]       tens,
    output logic [3:0]       units,
    output logic [6:0]       seg_tens,
    output logic [6:0]       seg_units
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [6:0] SEG_ZERO  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_TENS_RESET = BLANK_LZ ? SEG_BLANK : SEG_ZERO;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] last_reg;
    logic [7:0]       bcd_reg;
    logic [CW-1:0]    cnt_reg;

    logic [7:0]       bcd_adj;
    logic             start;

    // Add-3 correction on each BCD nibble ahead of the shift.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5)
                                      ? bcd_reg[gi*4 +: 4] + 4'd3
                                      : bcd_reg[gi*4 +: 4];
        end
    endgenerate

    assign start = load | (AUTO & (Q_in != last_reg));

    function automatic logic [6:0] seg7(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'b0111111;
            4'd1:    pattern = 7'b0000110;
            4'd2:    pattern = 7'b1011011;
            4'd3:    pattern = 7'b1001111;
            4'd4:    pattern = 7'b1100110;
            4'd5:    pattern = 7'b1101101;
            4'd6:    pattern = 7'b1111101;
            4'd7:    pattern = 7'b0000111;
            4'd8:    pattern = 7'b1111111;
            4'd9:    pattern = 7'b1101111;
            default: pattern = 7'b0000000;
        endcase
        return pattern;
    endfunction

    always_ff @(posedge clk) begin
        if (!CLR) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            tens      <= 4'd0;
            units     <= 4'd0;
            seg_tens  <= SEG_TENS_RESET;
            seg_units <= SEG_ZERO;
            last_reg  <= '0;
            shift_reg <= '0;
            bcd_reg   <= 8'd0;
            cnt_reg   <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        shift_reg <= Q_in;
                        last_reg  <= Q_in;
                        bcd_reg   <= 8'd0;
                        cnt_reg   <= CW'(WIDTH);
                        busy      <= 1'b1;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd_reg, shift_reg} <= {bcd_adj, shift_reg} << 1;
                    cnt_reg <= cnt_reg - 1'b1;
                    if (cnt_reg == CW'(1)) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    // All four display outputs change together on this edge only.
                    tens      <= bcd_reg[7:4];
                    units     <= bcd_reg[3:0];
                    seg_units <= seg7(bcd_reg[3:0]);
                    seg_tens  <= (BLANK_LZ && (bcd_reg[7:4] == 4'd0))
                               ? SEG_BLANK : seg7(bcd_reg[7:4]);
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_bcd_display.sv
// Directed bench for count_bcd_display: a manual-load/blanking instance and an
// auto-tracking/no-blanking instance share clock and reset.
module tb_count_bcd_display;

    logic       clk = 1'b0;
    logic       CLR = 1'b0;
    logic [5:0] q_a = 6'd0;
    logic [5:0] q_b = 6'd0;
    logic       load_a = 1'b0;
    logic       load_b = 1'b0;

    logic       busy_a, done_a, busy_b, done_b;
    logic [3:0] tens_a, units_a, tens_b, units_b;
    logic [6:0] seg_tens_a, seg_units_a, seg_tens_b, seg_units_b;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                 7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                 7'b1111111, 7'b1101111};

    always #5 clk = ~clk;

    count_bcd_display #(.WIDTH(6), .AUTO(1'b0), .BLANK_LZ(1'b1)) u_a (
        .clk(clk), .CLR(CLR), .Q_in(q_a), .load(load_a),
        .busy(busy_a), .done(done_a), .tens(tens_a), .units(units_a),
        .seg_tens(seg_tens_a), .seg_units(seg_units_a)
    );

    count_bcd_display #(.WIDTH(6), .AUTO(1'b1), .BLANK_LZ(1'b0)) u_b (
        .clk(clk), .CLR(CLR), .Q_in(q_b), .load(load_b),
        .busy(busy_b), .done(done_b), .tens(tens_b), .units(units_b),
        .seg_tens(seg_tens_b), .seg_units(seg_units_b)
    );

    // Advance on negedges until done is seen (returns on that negedge) or limit expires.
    task automatic wait_done_a(input int limit, output int busy_cycles, output bit seen);
        busy_cycles = 0;
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (done_a) begin
                seen = 1'b1;
                break;
            end
            if (busy_a) busy_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic wait_done_b(input int limit, output int busy_cycles, output bit seen);
        busy_cycles = 0;
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (done_b) begin
                seen = 1'b1;
                break;
            end
            if (busy_b) busy_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        CLR = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done_a); end
        checks++; if (tens_a !== 4'd0 || units_a !== 4'd0) begin errors++; $display("FAIL reset_digits got %0d%0d want 00", tens_a, units_a); end
        checks++; if (seg_units_a !== 7'b0111111) begin errors++; $display("FAIL reset_seg_units got %b want 0111111", seg_units_a); end
        checks++; if (seg_tens_a !== 7'b0000000) begin errors++; $display("FAIL reset_seg_tens_blank got %b want 0000000", seg_tens_a); end
        checks++; if (seg_tens_b !== 7'b0111111) begin errors++; $display("FAIL reset_seg_tens_noblank got %b want 0111111", seg_tens_b); end
        CLR = 1'b1;
        @(negedge clk);
        $display("reset: busy=%b done=%b tens=%0d units=%0d", busy_a, done_a, tens_a, units_a);
    endtask

    task automatic test_basic();
        int  bc;
        bit  seen;
        q_a = 6'd35; load_a = 1'b1;
        @(negedge clk);
        load_a = 1'b0;
        wait_done_a(30, bc, seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL basic_done_timeout got %b want 1", seen); end
        checks++; if (bc !== 7) begin errors++; $display("FAIL basic_busy_cycles got %0d want 7", bc); end
        checks++; if (tens_a !== 4'd3 || units_a !== 4'd5) begin errors++; $display("FAIL basic_digits got %0d%0d want 35", tens_a, units_a); end
        checks++; if (seg_tens_a !== 7'b1001111) begin errors++; $display("FAIL basic_seg_tens got %b want 1001111", seg_tens_a); end
        checks++; if (seg_units_a !== 7'b1101101) begin errors++; $display("FAIL basic_seg_units got %b want 1101101", seg_units_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %b want 0", busy_a); end
        @(negedge clk);
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b want 0", done_a); end
        $display("convert 35: busy_cycles=%0d tens=%0d units=%0d", bc, tens_a, units_a);
    endtask

    task automatic test_values();
        int  bc;
        bit  seen;
        q_a = 6'd10; load_a = 1'b1;
        @(negedge clk);
        load_a = 1'b0;
        wait_done_a(30, bc, seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL v10_done_timeout got %b want 1", seen); end
        checks++; if (tens_a !== 4'd1 || units_a !== 4'd0) begin errors++; $display("FAIL v10_digits got %0d%0d want 10", tens_a, units_a); end
        checks++; if (seg_tens_a !== 7'b0000110 || seg_units_a !== 7'b0111111) begin errors++; $display("FAIL v10_segs got %b %b want 0000110 0111111", seg_tens_a, seg_units_a); end
        $display("convert 10: tens=%0d units=%0d", tens_a, units_a);
        @(negedge clk);
        q_a = 6'd63; load_a = 1'b1;
        @(negedge clk);
        load_a = 1'b0;
        wait_done_a(30, bc, seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL v63_done_timeout got %b want 1", seen); end
        checks++; if (tens_a !== 4'd6 || units_a !== 4'd3) begin errors++; $display("FAIL v63_digits got %0d%0d want 63", tens_a, units_a); end
        checks++; if (seg_tens_a !== 7'b1111101 || seg_units_a !== 7'b1001111) begin errors++; $display("FAIL v63_segs got %b %b want 1111101 1001111", seg_tens_a, seg_units_a); end
        $display("convert 63: tens=%0d units=%0d", tens_a, units_a);
        @(negedge clk);
    endtask

    task automatic test_hold_load();
        int  bc;
        bit  seen;
        // Manual instance: value changes mid-conversion, load dropped at done.
        q_a = 6'd35; load_a = 1'b1;
        repeat (3) @(negedge clk);
        q_a = 6'd20;
        wait_done_a(30, bc, seen);
        load_a = 1'b0;
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL hold_a_done_timeout got %b want 1", seen); end
        checks++; if (tens_a !== 4'd3 || units_a !== 4'd5) begin errors++; $display("FAIL hold_a_digits got %0d%0d want 35", tens_a, units_a); end
        @(negedge clk);
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL hold_a_no_restart got busy=%b want 0", busy_a); end
        $display("hold manual: tens=%0d units=%0d busy_after=%b", tens_a, units_a, busy_a);
        // Auto instance: the changed value is picked up after done.
        q_b = 6'd35; load_b = 1'b1;
        repeat (3) @(negedge clk);
        q_b = 6'd20;
        wait_done_b(30, bc, seen);
        load_b = 1'b0;
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL hold_b_done_timeout got %b want 1", seen); end
        checks++; if (tens_b !== 4'd3 || units_b !== 4'd5) begin errors++; $display("FAIL hold_b_first_digits got %0d%0d want 35", tens_b, units_b); end
        @(negedge clk);
        wait_done_b(30, bc, seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL hold_b_second_timeout got %b want 1", seen); end
        checks++; if (tens_b !== 4'd2 || units_b !== 4'd0) begin errors++; $display("FAIL hold_b_second_digits got %0d%0d want 20", tens_b, units_b); end
        checks++; if (seg_tens_b !== 7'b1011011) begin errors++; $display("FAIL hold_b_seg_tens got %b want 1011011", seg_tens_b); end
        $display("hold auto: second tens=%0d units=%0d", tens_b, units_b);
        @(negedge clk);
    endtask

    task automatic test_abort();
        int dones;
        q_a = 6'd47; load_a = 1'b1;
        @(negedge clk);
        load_a = 1'b0;
        repeat (3) @(negedge clk);
        CLR = 1'b0;
        @(negedge clk);
        checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin errors++; $display("FAIL abort_flags got busy=%b done=%b want 0 0", busy_a, done_a); end
        checks++; if (tens_a !== 4'd0 || units_a !== 4'd0) begin errors++; $display("FAIL abort_digits got %0d%0d want 00", tens_a, units_a); end
        checks++; if (seg_tens_a !== 7'b0000000) begin errors++; $display("FAIL abort_seg_tens got %b want 0000000", seg_tens_a); end
        checks++; if (seg_tens_b !== 7'b0111111) begin errors++; $display("FAIL abort_seg_tens_b got %b want 0111111", seg_tens_b); end
        CLR = 1'b1;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done_a) dones++;
        end
        checks++; if (dones !== 0) begin errors++; $display("FAIL abort_no_done got %0d pulses want 0", dones); end
        $display("abort 47: done pulses after reset=%0d", dones);
    endtask

    task automatic test_blank();
        int  bc;
        bit  seen;
        q_a = 6'd0; load_a = 1'b1;
        q_b = 6'd0; load_b = 1'b1;
        @(negedge clk);
        load_a = 1'b0; load_b = 1'b0;
        wait_done_a(30, bc, seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL blank_a_timeout got %b want 1", seen); end
        checks++; if (seg_tens_a !== 7'b0000000 || seg_units_a !== 7'b0111111) begin errors++; $display("FAIL blank_a_segs got %b %b want 0000000 0111111", seg_tens_a, seg_units_a); end
        checks++; if (done_b !== 1'b1) begin errors++; $display("FAIL blank_b_done got %b want 1", done_b); end
        checks++; if (seg_tens_b !== 7'b0111111 || seg_units_b !== 7'b0111111) begin errors++; $display("FAIL blank_b_segs got %b %b want 0111111 0111111", seg_tens_b, seg_units_b); end
        $display("zero: seg_tens blank=%b noblank=%b", seg_tens_a, seg_tens_b);
        @(negedge clk);
    endtask

    task automatic test_counter();
        int         dones;
        logic [3:0] t_seen, u_seen;
        logic [6:0] s_seen;
        for (int v = 35; v >= 10; v--) begin
            q_b = 6'(v);
            dones = 0;
            t_seen = 4'hf; u_seen = 4'hf; s_seen = 7'h00;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (done_b) begin
                    dones++;
                    t_seen = tens_b; u_seen = units_b; s_seen = seg_units_b;
                end
            end
            checks++; if (dones !== 1) begin errors++; $display("FAIL count_%0d_done_pulses got %0d want 1", v, dones); end
            checks++; if (t_seen !== 4'(v / 10) || u_seen !== 4'(v % 10)) begin errors++; $display("FAIL count_%0d_digits got %0d%0d want %0d", v, t_seen, u_seen, v); end
            checks++; if (s_seen !== seg_tab[v % 10]) begin errors++; $display("FAIL count_%0d_seg_units got %b want %b", v, s_seen, seg_tab[v % 10]); end
            $display("count %0d: dones=%0d tens=%0d units=%0d", v, dones, t_seen, u_seen);
        end
        checks++; if (tens_b !== 4'd1 || units_b !== 4'd0) begin errors++; $display("FAIL count_final got %0d%0d want 10", tens_b, units_b); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_values();
        test_hold_load();
        test_abort();
        test_blank();
        test_counter();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
